// File: rtl/velocity_cache_dbuf.sv
// Double-buffered per-cell particle cache: multi-lane broadcast capture through a match FIFO
// into the back buffer, count word at address 0, then a buffer swap; front buffer serves reads.
module velocity_cache_dbuf #(
  parameter int DATA_WIDTH    = 32,
  parameter int COMPONENTS    = 3,
  parameter int DEPTH         = 256,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4,
  parameter int CELL_X        = 2,
  parameter int CELL_Y        = 2,
  parameter int CELL_Z        = 3,
  parameter int NUM_LANES     = 2,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      motion_update_enable,
  input  logic [NUM_LANES*COMPONENTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_LANES*3*CELL_ID_WIDTH-1:0]       in_data_dst_cell,
  input  logic [NUM_LANES-1:0]                       in_data_valid,
  input  logic                                      in_rden,
  input  logic [ADDR_WIDTH-1:0]                     in_read_address,
  output logic [COMPONENTS*DATA_WIDTH-1:0]          out_particle_info,
  output logic                                      busy,
  output logic                                      swap_done,
  output logic                                      active_sel,
  output logic [ADDR_WIDTH-1:0]                     particle_count,
  output logic                                      fifo_overflow,
  output logic                                      cell_full
);
  localparam int EW   = COMPONENTS * DATA_WIDTH;
  localparam int CW   = 3 * CELL_ID_WIDTH;
  localparam int FAW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MY_CELL = {CELL_ID_WIDTH'(CELL_X), CELL_ID_WIDTH'(CELL_Y),
                                       CELL_ID_WIDTH'(CELL_Z)};
  localparam logic [PW-1:0] PTR_END = PW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_DRAIN, S_WRITE_COUNT, S_SWAP} state_t;
  state_t state, state_n;

  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]  fifo_wp, fifo_rp;
  logic [CNTW-1:0] fifo_cnt, push_num;
  logic [NUM_LANES-1:0] push_en;
  logic [FAW-1:0]  push_idx [NUM_LANES];
  logic            capture, drop, pop;
  logic            pend_v;
  logic [EW-1:0]   pend_d;
  logic [PW-1:0]   wr_ptr;

  logic                  back_we;
  logic [ADDR_WIDTH-1:0] back_addr;
  logic [EW-1:0]         back_data;
  logic [EW-1:0]         mem0 [DEPTH];
  logic [EW-1:0]         mem1 [DEPTH];
  logic [EW-1:0]         ram_q0, ram_q1;
  logic                  rd_v1, rd_s1, rd_v2, rd_s2;
  logic [ADDR_WIDTH-1:0] rd_a1;

  assign capture = (state == S_COLLECT) || (state == S_IDLE && motion_update_enable);
  assign pop     = (fifo_cnt != '0);

  // The slot freed by this cycle's pop is available to this cycle's pushes.
  always_comb begin
    int unsigned free_slots;
    int unsigned k;
    push_en    = '0;
    drop       = 1'b0;
    k          = 0;
    free_slots = FIFO_DEPTH - 32'(fifo_cnt) + ((fifo_cnt != '0) ? 1 : 0);
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      push_idx[i] = FAW'((32'(fifo_wp) + k) % FIFO_DEPTH);
      if (capture && in_data_valid[i] && in_data_dst_cell[i*CW +: CW] == MY_CELL) begin
        if (k < free_slots) begin
          push_en[i] = 1'b1;
          k++;
        end else begin
          drop = 1'b1;
        end
      end
    end
    push_num = CNTW'(k);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
      pend_v   <= 1'b0;
    end else begin
      fifo_wp  <= FAW'((32'(fifo_wp) + 32'(push_num)) % FIFO_DEPTH);
      if (pop) fifo_rp <= FAW'((32'(fifo_rp) + 1) % FIFO_DEPTH);
      fifo_cnt <= fifo_cnt + push_num - CNTW'(pop);
      pend_v   <= pop;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_LANES; i++)
      if (push_en[i]) fifo_mem[push_idx[i]] <= in_data[i*EW +: EW];
    if (pop) pend_d <= fifo_mem[fifo_rp];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = (state != S_IDLE);
    unique case (state)
      S_IDLE:        if (motion_update_enable) state_n = S_COLLECT;
      S_COLLECT:     if (!motion_update_enable) state_n = S_DRAIN;
      S_DRAIN:       if (fifo_cnt == '0 && !pend_v) state_n = S_WRITE_COUNT;
      S_WRITE_COUNT: state_n = S_SWAP;
      S_SWAP:        state_n = S_IDLE;
      default:       state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= PW'(1);
      fifo_overflow <= 1'b0;
      cell_full     <= 1'b0;
      active_sel    <= 1'b0;
      swap_done     <= 1'b0;
    end else begin
      swap_done <= (state == S_SWAP);
      if (state == S_SWAP) active_sel <= ~active_sel;
      if (state == S_IDLE && motion_update_enable) begin
        wr_ptr        <= PW'(1);
        fifo_overflow <= 1'b0;
        cell_full     <= 1'b0;
      end
      if (drop) fifo_overflow <= 1'b1;
      if (pend_v) begin
        if (wr_ptr == PTR_END) cell_full <= 1'b1;
        else                   wr_ptr    <= wr_ptr + PW'(1);
      end
    end
  end

  assign particle_count = ADDR_WIDTH'(wr_ptr - PW'(1));
  assign back_we   = (pend_v && wr_ptr != PTR_END) || (state == S_WRITE_COUNT);
  assign back_addr = (state == S_WRITE_COUNT) ? '0 : ADDR_WIDTH'(wr_ptr);
  assign back_data = (state == S_WRITE_COUNT) ? EW'(wr_ptr - PW'(1)) : pend_d;

  // Back buffer is the one not selected by active_sel; its port is never read meanwhile.
  always_ff @(posedge clk) begin
    if (back_we && active_sel)   mem0[back_addr] <= back_data;
    else if (rd_v1 && !rd_s1)    ram_q0 <= mem0[rd_a1];
  end

  always_ff @(posedge clk) begin
    if (back_we && !active_sel)  mem1[back_addr] <= back_data;
    else if (rd_v1 && rd_s1)     ram_q1 <= mem1[rd_a1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v1             <= 1'b0;
      rd_s1             <= 1'b0;
      rd_a1             <= '0;
      rd_v2             <= 1'b0;
      rd_s2             <= 1'b0;
      out_particle_info <= '0;
    end else begin
      rd_v1 <= in_rden;
      rd_s1 <= active_sel;
      rd_a1 <= in_read_address;
      rd_v2 <= rd_v1;
      rd_s2 <= rd_s1;
      if (rd_v2) out_particle_info <= rd_s2 ? ram_q1 : ram_q0;
    end
  end
endmodule

// File: tb/tb_velocity_cache_dbuf.sv
// Scoreboard bench: two cache instances (default and small FIFO/buffer) share broadcast stimulus
// and are checked against a queue-level reference model of capture, FIFO admission and swap.
module tb_velocity_cache_dbuf;
  localparam int EW = 96;
  localparam logic [11:0] MY_CELL = 12'h223;
  localparam int FD [2] = '{8, 2};
  localparam int DP [2] = '{256, 4};
  localparam int MAXC = 64;

  typedef struct {
    logic sel;
    int   cnt;
    logic ovf;
    logic full;
  } swap_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic [2*EW-1:0] in_data = '0;
  logic [23:0] in_dst = '0;
  logic [1:0]  in_valid = '0;
  logic rden [2];
  logic [7:0] rd_addr = '0;

  logic [EW-1:0] opi [2];
  logic busy [2];
  logic swp [2];
  logic asel [2];
  logic ovf [2];
  logic full [2];
  logic [7:0] pc_a;
  logic [1:0] pc_b;

  int total = 0;
  int bad = 0;
  int swaps_seen [2];

  logic [1:0]    st_v   [MAXC];
  logic [11:0]   st_dst [MAXC][2];
  logic [EW-1:0] st_dat [MAXC][2];

  logic [EW-1:0] mdl_front [2][256];
  logic          mdl_sel [2];
  int            mdl_cnt [2];
  swap_t         sq0[$], sq1[$];
  logic [EW-1:0] rq0[$], rq1[$];

  always #5 clk = ~clk;

  velocity_cache_dbuf dut_a (
    .clk(clk), .rst(rst), .motion_update_enable(enable),
    .in_data(in_data), .in_data_dst_cell(in_dst), .in_data_valid(in_valid),
    .in_rden(rden[0]), .in_read_address(rd_addr),
    .out_particle_info(opi[0]), .busy(busy[0]), .swap_done(swp[0]),
    .active_sel(asel[0]), .particle_count(pc_a),
    .fifo_overflow(ovf[0]), .cell_full(full[0])
  );

  velocity_cache_dbuf #(.DEPTH(4), .ADDR_WIDTH(2), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .motion_update_enable(enable),
    .in_data(in_data), .in_data_dst_cell(in_dst), .in_data_valid(in_valid),
    .in_rden(rden[1]), .in_read_address(rd_addr[1:0]),
    .out_particle_info(opi[1]), .busy(busy[1]), .swap_done(swp[1]),
    .active_sel(asel[1]), .particle_count(pc_b),
    .fifo_overflow(ovf[1]), .cell_full(full[1])
  );

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic int pcount(input int d);
    return (d == 0) ? 32'(pc_a) : 32'(pc_b);
  endfunction

  // Queue-level model: each cycle the free space is capacity minus occupancy plus the slot
  // released by that cycle's pop; matches are admitted lowest lane first.
  task automatic model_update(input int d, input int n);
    logic [EW-1:0] q[$];
    logic [EW-1:0] acc[$];
    logic o;
    int cnt;
    swap_t e;
    o = 1'b0;
    for (int c = 0; c < n; c++) begin
      int sz;
      int fr;
      sz = q.size();
      fr = FD[d] - sz + ((sz > 0) ? 1 : 0);
      if (sz > 0) acc.push_back(q.pop_front());
      for (int l = 0; l < 2; l++)
        if (st_v[c][l] && st_dst[c][l] == MY_CELL) begin
          if (fr > 0) begin
            q.push_back(st_dat[c][l]);
            fr--;
          end else o = 1'b1;
        end
    end
    while (q.size() > 0) acc.push_back(q.pop_front());
    cnt = (acc.size() > DP[d] - 1) ? DP[d] - 1 : acc.size();
    mdl_sel[d] = ~mdl_sel[d];
    e.sel = mdl_sel[d];
    e.cnt = cnt;
    e.ovf = o;
    e.full = (acc.size() > DP[d] - 1);
    if (d == 0) sq0.push_back(e);
    else        sq1.push_back(e);
    mdl_cnt[d] = cnt;
    mdl_front[d][0] = EW'(cnt);
    for (int i = 0; i < cnt; i++) mdl_front[d][i+1] = acc[i];
  endtask

  task automatic drive_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      enable   = 1'b1;
      in_valid = st_v[c];
      in_dst   = {st_dst[c][1], st_dst[c][0]};
      in_data  = {st_dat[c][1], st_dat[c][0]};
    end
    @(negedge clk);
    enable   = 1'b0;
    in_valid = '0;
  endtask

  task automatic read_back(input int d);
    for (int a = 0; a <= mdl_cnt[d]; a++) begin
      @(negedge clk);
      rd_addr = 8'(a);
      rden[d] = 1'b1;
      if (d == 0) rq0.push_back(mdl_front[d][a]);
      else        rq1.push_back(mdl_front[d][a]);
    end
    @(negedge clk);
    rden[d] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_update(input int n);
    int t0, t1, i;
    t0 = swaps_seen[0] + 1;
    t1 = swaps_seen[1] + 1;
    model_update(0, n);
    model_update(1, n);
    drive_cycles(n);
    i = 0;
    while (i < 400 && !(swaps_seen[0] >= t0 && swaps_seen[1] >= t1)) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (i >= 400) begin
      bad++;
      $display("FAIL swap_timeout: got swaps %0d/%0d, want %0d/%0d",
               swaps_seen[0], swaps_seen[1], t0, t1);
    end
    read_back(0);
    read_back(1);
  endtask

  task automatic set_cycle(input int c, input logic [1:0] v, input logic [11:0] d0,
                           input logic [11:0] d1, input logic [EW-1:0] x0, input logic [EW-1:0] x1);
    st_v[c] = v;
    st_dst[c][0] = d0;
    st_dst[c][1] = d1;
    st_dat[c][0] = x0;
    st_dat[c][1] = x1;
  endtask

  function automatic logic [EW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [11:0] rnd_dst();
    int unsigned r;
    logic [11:0] x;
    r = $urandom_range(0, 3);
    x = 12'($urandom);
    return (r < 2) ? MY_CELL : ((r == 2) ? 12'h224 : x);
  endfunction

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_busy"},  EW'(busy[d]), '0);
      check({tag, "_swap"},  EW'(swp[d]),  '0);
      check({tag, "_asel"},  EW'(asel[d]), '0);
      check({tag, "_count"}, EW'(pcount(d)), '0);
      check({tag, "_ovf"},   EW'(ovf[d]),  '0);
      check({tag, "_full"},  EW'(full[d]), '0);
      check({tag, "_out"},   opi[d],       '0);
    end
  endtask

  // Monitor: read data is due two edges after the edge that sampled rden; swap records on swap_done.
  initial begin : monitor
    logic r1 [2];
    logic r2 [2];
    logic s  [2];
    logic [EW-1:0] exp;
    swap_t e;
    r1 = '{1'b0, 1'b0};
    r2 = '{1'b0, 1'b0};
    forever begin
      @(posedge clk);
      s[0] = rden[0];
      s[1] = rden[1];
      #1;
      for (int d = 0; d < 2; d++) begin
        if (r2[d]) begin
          if ((d == 0 && rq0.size() == 0) || (d == 1 && rq1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_read dut%0d: got %h, want no read", d, opi[d]);
          end else begin
            if (d == 0) exp = rq0.pop_front();
            else        exp = rq1.pop_front();
            check($sformatf("read_data_dut%0d", d), opi[d], exp);
          end
        end
        r2[d] = r1[d];
        r1[d] = s[d];
        if (swp[d] === 1'b1) begin
          swaps_seen[d]++;
          if ((d == 0 && sq0.size() == 0) || (d == 1 && sq1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_swap dut%0d: got swap_done=1, want 0", d);
          end else begin
            if (d == 0) e = sq0.pop_front();
            else        e = sq1.pop_front();
            check($sformatf("swap_sel_dut%0d", d),   EW'(asel[d]), EW'(e.sel));
            check($sformatf("swap_count_dut%0d", d), EW'(pcount(d)), EW'(e.cnt));
            check($sformatf("swap_ovf_dut%0d", d),   EW'(ovf[d]), EW'(e.ovf));
            check($sformatf("swap_full_dut%0d", d),  EW'(full[d]), EW'(e.full));
          end
        end
      end
    end
  end

  initial begin : stim
    logic [EW-1:0] a, b;
    rden = '{1'b0, 1'b0};
    swaps_seen = '{0, 0};
    mdl_sel = '{1'b0, 1'b0};
    mdl_cnt = '{0, 0};
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single lane, values 1,2,3
    for (int c = 0; c < 3; c++) set_cycle(c, 2'b01, MY_CELL, 12'h000, EW'(c + 1), '0);
    run_update(3);

    // both lanes in one cycle
    a = rnd_data();
    b = rnd_data();
    set_cycle(0, 2'b11, MY_CELL, MY_CELL, a, b);
    run_update(1);

    // three consecutive dual matches: small FIFO drops lane 1 twice, small buffer fills
    for (int c = 0; c < 3; c++) set_cycle(c, 2'b11, MY_CELL, MY_CELL, rnd_data(), rnd_data());
    run_update(3);

    // five single-lane matches overrun the 3-entry buffer
    for (int c = 0; c < 5; c++) set_cycle(c, 2'b01, MY_CELL, 12'h000, rnd_data(), '0);
    run_update(5);

    // valid but wrong cell: nothing written, flags clear, swap still happens
    for (int c = 0; c < 2; c++) set_cycle(c, 2'b11, 12'h224, 12'h224, rnd_data(), rnd_data());
    run_update(2);

    for (int u = 0; u < 6; u++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int c = 0; c < n; c++)
        set_cycle(c, 2'($urandom_range(0, 3)), rnd_dst(), rnd_dst(), rnd_data(), rnd_data());
      run_update(n);
    end

    // abort an update in DRAIN with reset
    for (int c = 0; c < 6; c++) set_cycle(c, 2'b11, MY_CELL, MY_CELL, rnd_data(), rnd_data());
    drive_cycles(6);
    @(negedge clk);
    check("drain_busy_dut0", EW'(busy[0]), EW'(1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    mdl_sel = '{1'b0, 1'b0};
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_swap_dut0", EW'(asel[0]), '0);

    for (int c = 0; c < 4; c++)
      set_cycle(c, 2'b11, MY_CELL, rnd_dst(), rnd_data(), rnd_data());
    run_update(4);

    repeat (5) @(negedge clk);
    check("leftover_reads", EW'(rq0.size() + rq1.size()), '0);
    check("leftover_swaps", EW'(sq0.size() + sq1.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/velocity_cache_dbuf.md
# velocity_cache_dbuf

Parametrised double-buffered per-cell particle cache (velocity or position) for the motion-update path, generalising the single-lane velocity cache. It accepts up to NUM_LANES broadcast particles per cycle, keeps the ones addressed to this cell, and serialises them through an internal FIFO into the back buffer. At the end of an update it writes the particle count to address 0 and swaps buffers. The front buffer serves force-pipeline reads throughout.

## Interface
- DATA_WIDTH, 32: width of one vector component.
- COMPONENTS, 3: components per entry; entry width EW = COMPONENTS*DATA_WIDTH, packed {c2,c1,c0}.
- DEPTH, 256: words per buffer; address 0 holds the count, addresses 1..DEPTH-1 hold particles.
- ADDR_WIDTH, 8: clog2(DEPTH).
- CELL_ID_WIDTH, 4: width of each cell coordinate.
- CELL_X, CELL_Y, CELL_Z, 2/2/3: this cell's ID.
- NUM_LANES, 2: broadcast lanes per cycle (1..4).
- FIFO_DEPTH, 8: match FIFO entries (power of 2, >= NUM_LANES).

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-low.
- motion_update_enable  in  1  held high for the whole broadcast phase.
- in_data  in  NUM_LANES*EW  lane i at bits [i*EW +: EW].
- in_data_dst_cell  in  NUM_LANES*3*CELL_ID_WIDTH  per lane {x,y,z}.
- in_data_valid  in  NUM_LANES  per-lane valid.
- in_rden  in  1  front-buffer read enable.
- in_read_address  in  ADDR_WIDTH  front-buffer address.
- out_particle_info  out  EW  read data.
- busy  out  1  high in any state other than IDLE.
- swap_done  out  1  one-cycle pulse when buffers swap.
- active_sel  out  1  current front-buffer index.
- particle_count  out  ADDR_WIDTH  particles accepted in the current or last update.
- fifo_overflow  out  1  sticky: a match was dropped for lack of FIFO space.
- cell_full  out  1  sticky: a match was dropped because the back buffer was full.

## Operation
- Match: lane i matches when in_data_valid[i] is high and its dst equals {CELL_X,CELL_Y,CELL_Z}. Matches count only in COLLECT, and in IDLE on the cycle motion_update_enable rises.
- FIFO push: all matches in a cycle are pushed in ascending lane order. If free slots < matches, the lowest lanes are kept, the rest are dropped, and fifo_overflow is set.
- Pop: one entry per cycle when the FIFO is non-empty. It is written to the back buffer at wr_ptr (starts at 1), then wr_ptr increments.
- If wr_ptr == DEPTH, the popped entry is discarded and cell_full is set. particle_count saturates at DEPTH-1.
- States:
  - IDLE: on motion_update_enable -> COLLECT. Clears wr_ptr=1, particle_count, fifo_overflow and cell_full, and captures that cycle's matches.
  - COLLECT: when motion_update_enable falls -> DRAIN.
  - DRAIN: when FIFO is empty and no write is pending -> WRITE_COUNT.
  - WRITE_COUNT: write wr_ptr-1 (zero-extended to EW) to back-buffer address 0 -> SWAP.
  - SWAP: toggle active_sel, pulse swap_done -> IDLE.
- Re-asserting motion_update_enable outside IDLE/COLLECT is ignored. The next update starts only from IDLE.
- Reads always target the front buffer. Buffer selection is sampled together with the address, so a read issued in the SWAP cycle returns old-front data.
- Memories are inferred single-port RAMs. Back-buffer writes and front-buffer reads never conflict.
- Reset (async, rst low): state=IDLE, active_sel=0, busy=0, swap_done=0, particle_count=0, both sticky flags=0, FIFO empty, out_particle_info=0. RAM contents are not cleared.
- Reset mid-update aborts it. No swap occurs and active_sel returns to 0.

## Timing
- Read latency is 2 cycles: address/rden sampled at edge k, out_particle_info valid after edge k+2. Output holds when in_rden is low.
- Match at cycle t with an empty FIFO: pushed at edge t, popped at t+1, RAM write committed at edge ending t+2.
- A sustained NUM_LANES matches per cycle overflows the FIFO after about FIFO_DEPTH/(NUM_LANES-1) cycles.
- Enable falling with the FIFO empty: WRITE_COUNT occurs 2 cycles later, SWAP 1 cycle after that. swap_done is high the cycle after SWAP is entered, coincident with the new active_sel.
- Maximum throughput is 1 write per cycle.

## Test plan
- Single lane: 3 matches to dst 12'h223 with values 1,2,3, then enable drops -> swap_done pulses once, active_sel=1, reads of addr 0..3 return 3,1,2,3 two cycles after issue.
- Dual lane: both lanes match in one cycle (A on lane0, B on lane1) -> addr1=A, addr2=B, particle_count=2.
- Non-matching dst 12'h224 with valid high -> nothing written, count word = 0, swap still occurs.
- FIFO_DEPTH=2, NUM_LANES=2, 3 consecutive dual-match cycles -> fifo_overflow=1, the dropped entries are lane1, and the count equals the accepted entries.
- DEPTH=4, 5 matches -> addresses 1..3 written, count=3, cell_full=1. Both flags clear when the next update starts.
- rst low during DRAIN -> all outputs at reset values, no swap. Asserting enable afterwards runs a clean update.
